edge_generator: RTL and testbench

//  Transmit-side counterpart of the edge-detection path: turns queued pulse requests into a clean

---
 rtl/edge_gen_pkg.sv | 20 ++
 rtl/edge_gen_phase_cnt.sv | 31 +++
 rtl/edge_generator.sv | 126 ++++++++++++
 tb/tb_edge_generator.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_gen_pkg.sv
// Shared types and helpers for the edge generator.
// Phase lengths use len-1 encoding in the down-counter.
package edge_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam int CNT_W_DEF  = 8;
  localparam int PCNT_W_DEF = 16;

  function automatic logic [31:0] len_m1(
    input logic [31:0] len
  );
    return (len == 32'd0) ? 32'd0 : len - 32'd1;
  endfunction

endpackage

// File: rtl/edge_gen_phase_cnt.sv
// Phase-length down-counter.
// Clear beats load, and load beats decrement.
module edge_gen_phase_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (dec_i) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/edge_generator.sv
// Queued pulse requests to a registered waveform.
// Exact high/low widths, with abort and a completed-pulse count.
module edge_generator
  import edge_gen_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PCNT_W = PCNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CNT_W-1:0]  req_high_len,
  input  logic [CNT_W-1:0]  req_low_len,
  input  logic              abort,
  output logic              signal_out,
  output logic              rise_strobe,
  output logic              fall_strobe,
  output logic              busy,
  output logic [PCNT_W-1:0] pulse_cnt
);

  state_e            state_q;
  logic              sig_q;
  logic              rise_q;
  logic              fall_q;
  logic [PCNT_W-1:0] pcnt_q;
  logic [CNT_W-1:0]  low_q;

  logic             cnt_zero;
  logic             cnt_clr;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_val;
  logic [CNT_W-1:0] hi_m1;
  logic [CNT_W-1:0] lo_m1;
  logic             active;
  logic             xfer;

  assign hi_m1 = CNT_W'(len_m1(32'(req_high_len)));
  assign lo_m1 = CNT_W'(len_m1(32'(req_low_len)));

  assign active    = (state_q != IDLE);
  assign req_ready = !abort &&
                     ((state_q == IDLE) ||
                      (state_q == LOW && cnt_zero));
  assign xfer      = req_valid && req_ready;

  assign cnt_clr  = abort && active;
  assign cnt_load = !cnt_clr &&
                    ((state_q == IDLE && xfer) ||
                     (state_q == HIGH && cnt_zero) ||
                     (state_q == LOW && cnt_zero && xfer));
  assign cnt_val  = (state_q == HIGH) ? low_q : hi_m1;
  assign cnt_dec  = !cnt_clr && active && !cnt_zero;

  edge_gen_phase_cnt #(
    .W(CNT_W)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (cnt_clr),
    .load_i (cnt_load),
    .val_i  (cnt_val),
    .dec_i  (cnt_dec),
    .zero_o (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sig_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      pcnt_q  <= '0;
      low_q   <= '0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (xfer) begin
            state_q <= HIGH;
            sig_q   <= 1'b1;
            rise_q  <= 1'b1;
            low_q   <= lo_m1;
          end
        end
        HIGH: begin
          if (abort || cnt_zero) begin
            state_q <= abort ? IDLE : LOW;
            sig_q   <= 1'b0;
            fall_q  <= 1'b1;
          end
        end
        LOW: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (cnt_zero) begin
            pcnt_q <= pcnt_q + PCNT_W'(1);
            if (xfer) begin
              // Back-to-back: the low phase just ended, rise now
              state_q <= HIGH;
              sig_q   <= 1'b1;
              rise_q  <= 1'b1;
              low_q   <= lo_m1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          sig_q   <= 1'b0;
        end
      endcase
    end
  end

  assign signal_out  = sig_q;
  assign rise_strobe = rise_q;
  assign fall_strobe = fall_q;
  assign busy        = active;
  assign pulse_cnt   = pcnt_q;

endmodule

// File: tb/tb_edge_generator.sv
// Bench for edge_generator: waveform-queue reference model
// plus directed scenarios and randomized traffic.
module tb_edge_generator;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready, req_ready2;
  logic [7:0]  req_high_len;
  logic [7:0]  req_low_len;
  logic        abort;
  logic        signal_out, signal_out2;
  logic        rise_strobe, rise_strobe2;
  logic        fall_strobe, fall_strobe2;
  logic        busy, busy2;
  logic [15:0] pulse_cnt;
  logic [3:0]  pulse_cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  edge_generator dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_high_len (req_high_len),
    .req_low_len  (req_low_len),
    .abort        (abort),
    .signal_out   (signal_out),
    .rise_strobe  (rise_strobe),
    .fall_strobe  (fall_strobe),
    .busy         (busy),
    .pulse_cnt    (pulse_cnt)
  );

  // Narrow pulse counter instance to exercise wrap in few cycles
  edge_generator #(.CNT_W(8), .PCNT_W(4)) dut2 (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready2),
    .req_high_len (req_high_len),
    .req_low_len  (req_low_len),
    .abort        (abort),
    .signal_out   (signal_out2),
    .rise_strobe  (rise_strobe2),
    .fall_strobe  (fall_strobe2),
    .busy         (busy2),
    .pulse_cnt    (pulse_cnt2)
  );

  // Model: queue of future output cycles, one entry per cycle
  typedef struct packed {
    bit lvl;
    bit last;
  } ent_t;

  ent_t mq[$];
  bit   cur_idle = 1;
  bit   cur_lvl  = 0;
  bit   cur_last = 0;
  bit   exp_rise = 0;
  bit   exp_fall = 0;
  int   m_cnt    = 0;
  bit   last_acc = 0;

  task automatic model_reset();
    mq.delete();
    cur_idle = 1;
    cur_lvl  = 0;
    cur_last = 0;
    exp_rise = 0;
    exp_fall = 0;
    m_cnt    = 0;
  endtask

  // One clock cycle: drive, compare at negedge, advance model at posedge
  task automatic step(input bit v, input int h, input int l, input bit ab);
    bit   exp_ready;
    bit   prev_lvl;
    int   hh, ll;
    ent_t e;
    req_valid    = v;
    req_high_len = 8'(h);
    req_low_len  = 8'(l);
    abort        = ab;
    @(negedge clk);
    exp_ready = !ab && (mq.size() == 0);
    checks += 8;
    if (signal_out !== cur_lvl) begin
      failures++;
      $display("FAIL model_sig t=%0t got=%b exp=%b", $time, signal_out, cur_lvl);
    end
    if (rise_strobe !== exp_rise) begin
      failures++;
      $display("FAIL model_rise t=%0t got=%b exp=%b", $time, rise_strobe, exp_rise);
    end
    if (fall_strobe !== exp_fall) begin
      failures++;
      $display("FAIL model_fall t=%0t got=%b exp=%b", $time, fall_strobe, exp_fall);
    end
    if (busy !== !cur_idle) begin
      failures++;
      $display("FAIL model_busy t=%0t got=%b exp=%b", $time, busy, !cur_idle);
    end
    if (pulse_cnt !== 16'(m_cnt)) begin
      failures++;
      $display("FAIL model_pcnt t=%0t got=%0d exp=%0d", $time, pulse_cnt, 16'(m_cnt));
    end
    if (pulse_cnt2 !== 4'(m_cnt)) begin
      failures++;
      $display("FAIL model_pcnt4 t=%0t got=%0d exp=%0d", $time, pulse_cnt2, 4'(m_cnt));
    end
    if (req_ready !== exp_ready) begin
      failures++;
      $display("FAIL model_ready t=%0t got=%b exp=%b", $time, req_ready, exp_ready);
    end
    if (signal_out2 !== signal_out) begin
      failures++;
      $display("FAIL dut2_sig t=%0t got=%b exp=%b", $time, signal_out2, cur_lvl);
    end
    @(posedge clk);
    prev_lvl = cur_lvl;
    last_acc = v && exp_ready;
    if (ab && !cur_idle) begin
      mq.delete();
      cur_idle = 1;
      cur_lvl  = 0;
      cur_last = 0;
    end else begin
      if (!cur_idle && cur_last) m_cnt++;
      if (last_acc) begin
        hh = (h == 0) ? 1 : h;
        ll = (l == 0) ? 1 : l;
        for (int i = 0; i < hh; i++) mq.push_back('{lvl: 1'b1, last: 1'b0});
        for (int i = 0; i < ll; i++) mq.push_back('{lvl: 1'b0, last: (i == ll - 1)});
      end
      if (mq.size() > 0) begin
        e = mq.pop_front();
        cur_idle = 0;
        cur_lvl  = e.lvl;
        cur_last = e.last;
      end else begin
        cur_idle = 1;
        cur_lvl  = 0;
        cur_last = 0;
      end
    end
    exp_rise = cur_lvl && !prev_lvl;
    exp_fall = prev_lvl && !cur_lvl;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 0;
    req_high_len = 0;
    req_low_len = 0;
    abort = 0;
    @(posedge clk);
    #1;
    checks++;
    if ({signal_out, rise_strobe, fall_strobe, busy} !== 4'b0 || pulse_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_state got sig=%b r=%b f=%b busy=%b pcnt=%0d exp=all0",
               signal_out, rise_strobe, fall_strobe, busy, pulse_cnt);
    end
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", req_ready);
    end
  endtask

  task automatic test_basic();
    bit pat [1:6];
    int base;
    pat = '{1, 1, 1, 0, 0, 0};
    base = m_cnt;
    step(1, 3, 2, 0);
    for (int c = 1; c <= 6; c++) begin
      checks += 3;
      if (signal_out !== pat[c]) begin
        failures++;
        $display("FAIL basic_sig cyc=%0d got=%b exp=%b", c, signal_out, pat[c]);
      end
      if (rise_strobe !== (c == 1) || fall_strobe !== (c == 4)) begin
        failures++;
        $display("FAIL basic_strobe cyc=%0d got=%b%b exp=%b%b",
                 c, rise_strobe, fall_strobe, c == 1, c == 4);
      end
      if (busy !== (c <= 5)) begin
        failures++;
        $display("FAIL basic_busy cyc=%0d got=%b exp=%b", c, busy, c <= 5);
      end
      if (c == 5) begin
        checks++;
        if (req_ready !== 1'b1) begin
          failures++;
          $display("FAIL basic_ready5 got=%b exp=1", req_ready);
        end
      end
      step(0, 0, 0, 0);
    end
    checks++;
    if (pulse_cnt !== 16'(base + 1)) begin
      failures++;
      $display("FAIL basic_pcnt got=%0d exp=%0d", pulse_cnt, base + 1);
    end
  endtask

  task automatic test_zero_len();
    bit [3:0] w0, w1;
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      w0[i] = signal_out;
      step(0, 0, 0, 0);
    end
    step(1, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      w1[i] = signal_out;
      step(0, 0, 0, 0);
    end
    checks += 2;
    if (w0 !== 4'b0001) begin
      failures++;
      $display("FAIL zero_len_wave got=%b exp=0001", w0);
    end
    if (w0 !== w1) begin
      failures++;
      $display("FAIL zero_eq_one got=%b exp=%b", w0, w1);
    end
  endtask

  task automatic test_back_to_back();
    bit [8:0] pat;
    int rises, base;
    rises = 0;
    base = m_cnt;
    for (int k = 0; k < 9; k++) begin
      step(1, 2, 1, 0);
      pat[k] = signal_out;
      if (rise_strobe) rises++;
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    checks += 3;
    if (pat !== 9'b011011011) begin
      failures++;
      $display("FAIL b2b_pattern got=%b exp=011011011", pat);
    end
    if (rises != 3) begin
      failures++;
      $display("FAIL b2b_rises got=%0d exp=3", rises);
    end
    if (pulse_cnt !== 16'(base + 3)) begin
      failures++;
      $display("FAIL b2b_pcnt got=%0d exp=%0d", pulse_cnt, base + 3);
    end
  endtask

  task automatic test_abort();
    int base, falls;
    base = m_cnt;
    falls = 0;
    step(1, 5, 3, 0);
    step(0, 0, 0, 0);
    step(1, 4, 4, 1);
    checks += 3;
    if (signal_out !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_stop got sig=%b busy=%b exp=0 0", signal_out, busy);
    end
    if (last_acc !== 1'b0) begin
      failures++;
      $display("FAIL abort_accept got=%b exp=0", last_acc);
    end
    if (fall_strobe) falls++;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      if (fall_strobe) falls++;
    end
    if (falls != 1) begin
      failures++;
      $display("FAIL abort_falls got=%0d exp=1", falls);
    end
    checks += 2;
    if (pulse_cnt !== 16'(base)) begin
      failures++;
      $display("FAIL abort_pcnt got=%0d exp=%0d", pulse_cnt, base);
    end
    step(0, 0, 0, 1);
    if (signal_out !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle got=%b exp=0", signal_out);
    end
  endtask

  task automatic test_long();
    int hi, bz;
    hi = 0;
    bz = 0;
    step(1, 255, 255, 0);
    for (int i = 0; i < 520; i++) begin
      if (signal_out) hi++;
      if (busy) bz++;
      step(0, 0, 0, 0);
    end
    checks += 2;
    if (hi != 255) begin
      failures++;
      $display("FAIL long_high got=%0d exp=255", hi);
    end
    if (bz != 510) begin
      failures++;
      $display("FAIL long_busy got=%0d exp=510", bz);
    end
  endtask

  task automatic test_wrap();
    bit wrap_seen;
    logic [3:0] prev;
    wrap_seen = 0;
    prev = pulse_cnt2;
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 1, 0);
      if (prev == 4'hF && pulse_cnt2 == 4'h0) wrap_seen = 1;
      prev = pulse_cnt2;
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    checks += 2;
    if (!wrap_seen) begin
      failures++;
      $display("FAIL wrap_seen got=0 exp=1");
    end
    if (pulse_cnt2 !== 4'(m_cnt)) begin
      failures++;
      $display("FAIL wrap_value got=%0d exp=%0d", pulse_cnt2, 4'(m_cnt));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0,
           int'($urandom_range(0, 6)),
           int'($urandom_range(0, 6)),
           $urandom_range(0, 19) == 0);
    end
  endtask

  task automatic test_async_reset();
    step(1, 10, 2, 0);
    step(0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    checks += 2;
    if (signal_out !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL areset_out got sig=%b busy=%b exp=0 0", signal_out, busy);
    end
    if (pulse_cnt !== 16'd0) begin
      failures++;
      $display("FAIL areset_pcnt got=%0d exp=0", pulse_cnt);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(0, 0, 0, 0);
    step(1, 2, 2, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_back_to_back();
    test_abort();
    test_long();
    test_wrap();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
